// File: rtl/alu_pkg.sv
// Shared types for the 128-bit ALU front-end: controller states and the
// flag group used for both the ALU-facing and response-facing flags.
package alu_pkg;

    localparam int unsigned ALU_DWIDTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } ctrl_state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec_timer.sv
// Loadable 4-bit down-counter that measures the ALU settle window.
// done is high while the count reads zero; the count parks at zero.
module alu_exec_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       en,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_128bit_ctrl.sv
// Sequential front-end for the combinational 128-bit ALU. The path from the
// alu_* registers through the ALU to the rsp_* registers is an EXEC_CYCLES multicycle path.
module alu_128bit_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DWIDTH      = ALU_DWIDTH,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DWIDTH-1:0] req_op1,
    input  logic [DWIDTH-1:0] req_op2,
    input  logic [2:0]        req_opsel,
    input  logic              req_mode,
    output logic [DWIDTH-1:0] alu_op1,
    output logic [DWIDTH-1:0] alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_o,
    input  logic              alu_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_result,
    output logic              rsp_c,
    output logic              rsp_z,
    output logic              rsp_o,
    output logic              rsp_s,
    output logic              busy,
    output logic [15:0]       op_count
);

    ctrl_state_t state, next_state;
    alu_flags_t  alu_flags, rsp_flags;
    logic        accept, capture, handoff, timer_done;

    assign alu_flags = '{c: alu_c, z: alu_z, o: alu_o, s: alu_s};

    alu_exec_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_value (4'(EXEC_CYCLES - 1)),
        .en         (state == EXEC),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // req_ready depends only on state and rsp_ready, never on req_valid.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        capture    = 1'b0;
        handoff    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = EXEC;
            end
            EXEC: begin
                if (timer_done) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    req_ready  = 1'b1;
                    handoff    = 1'b1;
                    next_state = req_valid ? EXEC : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_opsel <= '0;
            alu_mode  <= 1'b0;
        end else if (accept) begin
            alu_op1   <= req_op1;
            alu_op2   <= req_op2;
            alu_opsel <= req_opsel;
            alu_mode  <= req_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
        end
    end

    assign rsp_c = rsp_flags.c;
    assign rsp_z = rsp_flags.z;
    assign rsp_o = rsp_flags.o;
    assign rsp_s = rsp_flags.s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (handoff) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_128bit_ctrl.sv
// Directed bench for alu_128bit_ctrl using an XOR stub ALU; expected values
// are hand-computed per vector.
module tb_alu_128bit_ctrl;

    localparam int unsigned DW   = 128;
    localparam int unsigned EXEC = 2;
    localparam int unsigned WAIT_LIMIT = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [DW-1:0] req_op1, req_op2;
    logic [2:0]    req_opsel;
    logic          req_mode;
    logic [DW-1:0] alu_op1, alu_op2;
    logic [2:0]    alu_opsel;
    logic          alu_mode;
    logic [DW-1:0] alu_result;
    logic          alu_c, alu_z, alu_o, alu_s;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_c, rsp_z, rsp_o, rsp_s;
    logic          busy;
    logic [15:0]   op_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stub ALU
    assign alu_result = alu_op1 ^ alu_op2;
    assign alu_z      = (alu_result == '0);
    assign alu_s      = alu_result[DW-1];
    assign alu_c      = alu_opsel[0];
    assign alu_o      = alu_mode;

    alu_128bit_ctrl #(.DWIDTH(DW), .EXEC_CYCLES(EXEC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_opsel  (req_opsel),
        .req_mode   (req_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opsel  (alu_opsel),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_o      (alu_o),
        .alu_s      (alu_s),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_c      (rsp_c),
        .rsp_z      (rsp_z),
        .rsp_o      (rsp_o),
        .rsp_s      (rsp_s),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                           input logic [2:0] opsel, input logic mode);
        req_op1   = op1;
        req_op2   = op2;
        req_opsel = opsel;
        req_mode  = mode;
        req_valid = 1'b1;
    endtask

    // Returns #1 after the accepting edge; req_valid is left asserted.
    task automatic wait_accept(input string tag);
        int unsigned n = 0;
        while (!req_ready && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_accept_timeout"}, DW'(n >= WAIT_LIMIT), '0);
        tick();
    endtask

    task automatic expect_rsp(input string tag, input logic [DW-1:0] res, input logic [3:0] flags);
        check({tag, "_rsp_valid"}, DW'(rsp_valid), 1);
        check({tag, "_result"}, rsp_result, res);
        check({tag, "_flags_czos"}, DW'({rsp_c, rsp_z, rsp_o, rsp_s}), DW'(flags));
    endtask

    // Single transaction with rsp_ready high; checks latency, response and count.
    task automatic run_single(input string tag, input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                              input logic [2:0] opsel, input logic mode,
                              input logic [DW-1:0] res, input logic [3:0] flags,
                              input logic [15:0] count_after);
        present(op1, op2, opsel, mode);
        wait_accept(tag);
        req_valid = 1'b0;
        for (int i = 1; i < int'(EXEC); i++) begin
            tick();
            check({tag, "_early_rsp"}, DW'(rsp_valid), 0);
        end
        tick();
        expect_rsp(tag, res, flags);
        tick();
        check({tag, "_rsp_drop"}, DW'(rsp_valid), 0);
        check({tag, "_op_count"}, DW'(op_count), DW'(count_after));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op1   = '0;
        req_op2   = '0;
        req_opsel = '0;
        req_mode  = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        check("rst_req_ready", DW'(req_ready), 1);
        check("rst_busy", DW'(busy), 0);
        check("rst_rsp_valid", DW'(rsp_valid), 0);
        check("rst_op_count", DW'(op_count), 0);
        check("rst_alu_op1", alu_op1, '0);
        check("rst_rsp_result", rsp_result, '0);

        // Basic single request, checked edge by edge
        rsp_ready = 1'b1;
        present(128'hFF, 128'h0F, 3'b001, 1'b0);
        wait_accept("t1");
        req_valid = 1'b0;
        check("t1_alu_op1", alu_op1, 128'hFF);
        check("t1_alu_op2", alu_op2, 128'h0F);
        check("t1_alu_opsel", DW'(alu_opsel), 1);
        check("t1_busy", DW'(busy), 1);
        check("t1_req_ready_exec", DW'(req_ready), 0);
        check("t1_rsp_n0", DW'(rsp_valid), 0);
        tick();
        check("t1_rsp_n1", DW'(rsp_valid), 0);
        tick();
        expect_rsp("t1", 128'hF0, 4'b1000);
        tick();
        check("t1_op_count", DW'(op_count), 1);
        check("t1_idle_busy", DW'(busy), 0);
        check("t1_rsp_hold", rsp_result, 128'hF0);
        check("t1_alu_hold", alu_op1, 128'hFF);

        // Zero and sign flags
        run_single("t2z", {1'b1, 126'b0, 1'b1}, {1'b1, 126'b0, 1'b1}, 3'b010, 1'b1,
                   '0, 4'b0110, 16'd2);
        run_single("t2s", {1'b1, 127'b0}, '0, 3'b111, 1'b0,
                   {1'b1, 127'b0}, 4'b1001, 16'd3);

        // Back-to-back: second request accepted in the RESP cycle
        present(128'h1234, 128'h00FF, 3'b000, 1'b0);
        wait_accept("t3a");
        present(128'hAAAA, 128'h5555, 3'b011, 1'b1);
        tick();
        check("t3_rsp_n1", DW'(rsp_valid), 0);
        tick();
        expect_rsp("t3a", 128'h12CB, 4'b0000);
        check("t3_req_ready_resp", DW'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check("t3_rsp_drop", DW'(rsp_valid), 0);
        check("t3_busy", DW'(busy), 1);
        check("t3_alu_op1_b", alu_op1, 128'hAAAA);
        check("t3_op_count_a", DW'(op_count), 4);
        tick();
        check("t3_rsp_n4", DW'(rsp_valid), 0);
        tick();
        expect_rsp("t3b", 128'hFFFF, 4'b1010);
        tick();
        check("t3_op_count_b", DW'(op_count), 5);

        // Stall with a pending request
        rsp_ready = 1'b0;
        present(128'hF0F0, 128'h0F0F, 3'b100, 1'b0);
        wait_accept("t4c");
        present(128'h3, 128'h3, 3'b001, 1'b0);
        tick();
        tick();
        expect_rsp("t4c", 128'hFFFF, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_stall_req_ready", DW'(req_ready), 0);
            check("t4_stall_rsp_valid", DW'(rsp_valid), 1);
            check("t4_stall_rsp_result", rsp_result, 128'hFFFF);
            check("t4_stall_alu_op1", alu_op1, 128'hF0F0);
            check("t4_stall_op_count", DW'(op_count), 5);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_req_ready_release", DW'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check("t4_op_count", DW'(op_count), 6);
        check("t4_busy", DW'(busy), 1);
        check("t4_rsp_drop", DW'(rsp_valid), 0);
        check("t4_alu_op1_d", alu_op1, 128'h3);
        tick();
        tick();
        expect_rsp("t4d", '0, 4'b1100);
        tick();
        check("t4_op_count_d", DW'(op_count), 7);

        // Reset during EXEC
        present(128'h55, 128'h0, 3'b001, 1'b0);
        wait_accept("t5");
        req_valid = 1'b0;
        check("t5_in_exec", DW'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", DW'(busy), 0);
        check("t5_rst_rsp_valid", DW'(rsp_valid), 0);
        check("t5_rst_alu_op1", alu_op1, '0);
        check("t5_rst_op_count", DW'(op_count), 0);
        check("t5_rst_rsp_result", rsp_result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_rsp", DW'(rsp_valid), 0);
        end
        run_single("t5_after", 128'h1, 128'h2, 3'b000, 1'b0, 128'h3, 4'b0000, 16'd1);

        // op_count wrap
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        check("t6_preset", DW'(op_count), 16'hFFFF);
        run_single("t6_wrap", 128'h7, 128'h1, 3'b000, 1'b0, 128'h6, 4'b0000, 16'h0000);
        run_single("t6_next", 128'h7, 128'h7, 3'b001, 1'b0, '0, 4'b1100, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
